// File: rtl/adder_err_monitor.sv
// -----------------------------------------------------------------------------
// adder_err_monitor
//
// Purpose:
//   Measures how far an approximate adder's results are from the exact sum.
//   A run is started with a sample count. Each accepted sample (op_a, op_b,
//   approx_sum) goes through a two-stage pipeline:
//     stage 1 registers the exact sum and the approximate sum,
//     stage 2 registers the absolute error,
//   and then the error is folded into the run accumulators. When the run
//   finishes, done pulses for one cycle and the results hold until the next
//   accepted start.
//
// Optional feature:
//   Define ADDER_ERR_MONITOR_MAX_EN to add the max_abs_err output. It reports
//   the largest absolute error seen in the run. With the macro undefined,
//   the port and its logic are absent.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (only honoured in IDLE)
//   num_samples  in   samples per run, latched on an accepted start
//   in_valid     in   sample present
//   in_ready     out  monitor accepts a sample this cycle (RUN only)
//   op_a, op_b   in   operands fed to the approximate adder
//   approx_sum   in   approximate adder result, MSB = carry out
//   busy         out  high from accepted start until done
//   done         out  one-cycle pulse, results valid
//   err_count    out  number of samples whose approx_sum differed
//   max_abs_err  out  largest |exact - approx| (ADDER_ERR_MONITOR_MAX_EN only)
//   sum_abs_err  out  saturating sum of |exact - approx| over the run
// -----------------------------------------------------------------------------
module adder_err_monitor #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
`ifdef ADDER_ERR_MONITOR_MAX_EN
  output logic [WIDTH:0]   max_abs_err,
`endif
  output logic [ACC_W-1:0] sum_abs_err
);

  // Error width, and a sum width wide enough that one addition of an error
  // to the accumulator can never overflow, whichever of the two is wider.
  localparam int EW = WIDTH + 1;
  localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q;
  logic [15:0]     n_q;
  logic [15:0]     acc_cnt_q;
  logic            in_ready_q;
  logic            busy_q;
  logic            done_q;

  logic            s1_valid_q, s1_valid_d;
  logic [EW-1:0]   s1_exact_q, s1_exact_d;
  logic [EW-1:0]   s1_approx_q, s1_approx_d;
  logic            s2_valid_q, s2_valid_d;
  logic [EW-1:0]   s2_err_q, s2_err_d;
  logic [15:0]     err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_q, sum_d;
`ifdef ADDER_ERR_MONITOR_MAX_EN
  logic [EW-1:0]   max_q, max_d;
`endif

  logic            accept;
  logic            start_accept;
  logic            last_accept;
  logic            pipe_empty;
  logic [SW-1:0]   sum_ext;

  assign accept       = in_valid & in_ready_q;
  assign start_accept = (state_q == IDLE) & start;
  assign last_accept  = accept & (acc_cnt_q == (n_q - 16'd1));
  assign pipe_empty   = ~s1_valid_q & ~s2_valid_q;

  // Datapath next-state: stage 1 captures on acceptance, stage 2 forms the
  // absolute error, and the accumulators absorb stage 2's result. A start
  // only happens in IDLE, when the pipeline is already empty, so clearing
  // and accumulating never compete.
  always_comb begin
    s1_valid_d  = accept;
    s1_exact_d  = s1_exact_q;
    s1_approx_d = s1_approx_q;
    if (accept) begin
      s1_exact_d  = {1'b0, op_a} + {1'b0, op_b};
      s1_approx_d = approx_sum;
    end

    s2_valid_d = s1_valid_q;
    s2_err_d   = s2_err_q;
    if (s1_valid_q) begin
      s2_err_d = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                             : (s1_approx_q - s1_exact_q);
    end

    sum_ext     = SW'(sum_q) + SW'(s2_err_q);
    err_count_d = err_count_q;
    sum_d       = sum_q;
`ifdef ADDER_ERR_MONITOR_MAX_EN
    max_d       = max_q;
`endif
    if (start_accept) begin
      err_count_d = '0;
      sum_d       = '0;
`ifdef ADDER_ERR_MONITOR_MAX_EN
      max_d       = '0;
`endif
    end else if (s2_valid_q) begin
      if (s2_err_q != '0) begin
        err_count_d = err_count_q + 16'd1;
      end
      // Any bit above the accumulator width means the sum passed full scale.
      sum_d = (|sum_ext[SW-1:ACC_W]) ? '1 : sum_ext[ACC_W-1:0];
`ifdef ADDER_ERR_MONITOR_MAX_EN
      if (s2_err_q > max_q) begin
        max_d = s2_err_q;
      end
`endif
    end
  end

  // Pipeline and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_approx_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_err_q    <= '0;
      err_count_q <= '0;
      sum_q       <= '0;
`ifdef ADDER_ERR_MONITOR_MAX_EN
      max_q       <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      s2_valid_q  <= s2_valid_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
      sum_q       <= sum_d;
`ifdef ADDER_ERR_MONITOR_MAX_EN
      max_q       <= max_d;
`endif
    end
  end

  // Run control. Outputs are registered alongside the state so that
  // in_ready is high exactly while in RUN, busy covers the accepted start
  // through the DONE state, and done pulses as the FSM returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      acc_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q    <= 1'b1;
            acc_cnt_q <= '0;
            if (num_samples != 16'd0) begin
              state_q    <= RUN;
              n_q        <= num_samples;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_q + 16'd1;
          end
          if (last_accept) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_count   = err_count_q;
  assign sum_abs_err = sum_q;
`ifdef ADDER_ERR_MONITOR_MAX_EN
  assign max_abs_err = max_q;
`endif

endmodule
